// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD SPI init/write sequencer.
package lcd_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam logic [ADDR_W-1:0] LCD_DELAY_ADDR = 7'h7F;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FETCH     = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;
   localparam logic [2:0] ST_DELAY     = 3'd5;
   localparam logic [2:0] ST_READY     = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_FETCH     = ST_FETCH,
      S_ISSUE     = ST_ISSUE,
      S_WAIT_DONE = ST_WAIT_DONE,
      S_GAP       = ST_GAP,
      S_DELAY     = ST_DELAY,
      S_READY     = ST_READY
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rom_entry_t;

endpackage

// File: rtl/lcd_spi_sequencer_if.sv
// Host write request port plus SPI transceiver TX port of the sequencer.
interface lcd_spi_sequencer_if;
   logic                        i_wrValid;
   logic [lcd_pkg::ADDR_W-1:0]  i_wrAddress;
   logic [lcd_pkg::DATA_W-1:0]  i_wrData;
   logic                        o_wrReady;
   logic                        o_txBegin;
   logic [lcd_pkg::ADDR_W-1:0]  o_txAddress;
   logic [lcd_pkg::DATA_W-1:0]  o_txData;
   logic                        i_txBusy;
   logic                        i_txDone;

   // master: the sequencer; slave: host + SPI transceiver side
   modport master (
      input  i_wrValid, i_wrAddress, i_wrData, i_txBusy, i_txDone,
      output o_wrReady, o_txBegin, o_txAddress, o_txData
   );
   modport slave (
      output i_wrValid, i_wrAddress, i_wrData, i_txBusy, i_txDone,
      input  o_wrReady, o_txBegin, o_txAddress, o_txData
   );
endinterface

// File: rtl/lcd_init_rom.sv
// LCD init table: index -> {register address, data}. Indices past the table read as 0.
module lcd_init_rom
   import lcd_pkg::*;
#(
   parameter int NUM_ENTRIES = 16
) (
   input  logic [7:0]  i_index,
   output rom_entry_t  o_entry
);

   always_comb begin
      o_entry = '0;
      if (32'(i_index) < 32'(NUM_ENTRIES)) begin
         case (i_index)
            8'd0:    o_entry = {7'h12, 8'h34};
            8'd1:    o_entry = {7'h13, 8'h56};
            8'd2:    o_entry = {7'h7F, 8'h03};  // delay entry when delays are enabled
            8'd3:    o_entry = {7'h14, 8'h78};
            8'd4:    o_entry = {7'h15, 8'h00};
            8'd5:    o_entry = {7'h16, 8'h01};
            8'd6:    o_entry = {7'h17, 8'h02};
            8'd7:    o_entry = {7'h18, 8'h10};
            8'd8:    o_entry = {7'h19, 8'h20};
            8'd9:    o_entry = {7'h1A, 8'h40};
            8'd10:   o_entry = {7'h1B, 8'h80};
            8'd11:   o_entry = {7'h1C, 8'hFF};
            8'd12:   o_entry = {7'h1D, 8'h0F};
            8'd13:   o_entry = {7'h1E, 8'hF0};
            8'd14:   o_entry = {7'h1F, 8'h5A};
            8'd15:   o_entry = {7'h20, 8'hA5};
            default: o_entry = '0;
         endcase
      end
   end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// Walks the LCD init table over SPI on start, then forwards single host register writes.
// Optional LCD_SEQ_DELAY_EN: table entries addressed 7'h7F become timed delays.
module lcd_spi_sequencer
   import lcd_pkg::*;
#(
   parameter int NUM_ENTRIES = 16,
   parameter int GAP_CYCLES  = 2,
   parameter int DELAY_UNIT  = 1000
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   output logic                 o_busy,
   output logic                 o_initDone,
   output logic [7:0]           o_tableIndex,
   lcd_spi_sequencer_if.master  bus
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 2);
`ifdef LCD_SEQ_DELAY_EN
   localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
`else
   // DELAY_UNIT only sizes the counter when delays are enabled
   localparam int DLY_W = (DELAY_UNIT > 0) ? 1 : 1;
`endif
   localparam int CNT_W = (DLY_W > GAP_W) ? DLY_W : GAP_W;
   localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

   state_e             state_q, state_d;
   logic [7:0]         idx_q, idx_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               host_q, host_d;
   logic               done_q, done_d;
   logic               step;
   rom_entry_t         rom;

   lcd_init_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
      .i_index (idx_q),
      .o_entry (rom)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         host_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         host_q  <= host_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      addr_d        = addr_q;
      data_d        = data_q;
      cnt_d         = cnt_q;
      host_d        = host_q;
      done_d        = done_q;
      step          = 1'b0;
      bus.o_txBegin = 1'b0;
      bus.o_wrReady = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               idx_d   = '0;
               host_d  = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            addr_d  = rom.addr;
            data_d  = rom.data;
            state_d = S_ISSUE;
`ifdef LCD_SEQ_DELAY_EN
            if (rom.addr == LCD_DELAY_ADDR) begin
               state_d = S_DELAY;
               cnt_d   = (rom.data == '0) ? '0 : CNT_W'(32'(rom.data) * DELAY_UNIT - 1);
            end
`endif
         end
         // waiting on busy also covers a transceiver still mid-frame after our reset
         S_ISSUE: begin
            if (!bus.i_txBusy) begin
               bus.o_txBegin = 1'b1;
               state_d       = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (bus.i_txDone) begin
               if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  cnt_d   = CNT_W'(GAP_CYCLES - 1);
               end else begin
                  step = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == '0) step = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
         end
`ifdef LCD_SEQ_DELAY_EN
         S_DELAY: begin
            if (cnt_q == '0) step = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
         end
`endif
         S_READY: begin
            bus.o_wrReady = !bus.i_txBusy;
            // an accepted write takes priority over a same-cycle start
            if (bus.i_wrValid && !bus.i_txBusy) begin
               addr_d  = bus.i_wrAddress;
               data_d  = bus.i_wrData;
               host_d  = 1'b1;
               state_d = S_ISSUE;
            end else if (i_start) begin
               done_d  = 1'b0;
               idx_d   = '0;
               host_d  = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (step) begin
         if (host_q) begin
            state_d = S_READY;
         end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_READY;
         end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
         end
      end
   end

   assign o_busy          = !(state_q == S_IDLE || state_q == S_READY);
   assign o_initDone      = done_q;
   assign o_tableIndex    = idx_q;
   assign bus.o_txAddress = addr_q;
   assign bus.o_txData    = data_q;

endmodule
